// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped bridge between the CPU memory stage and the uart: status,
// RX/TX byte FIFOs and cycle/instruction counters in a 256-byte I/O window.
module uart_mmio_ctrl #(
  parameter logic [31:0] IO_BASE  = 32'h8000_0000,
  parameter int          RX_DEPTH = 8,
  parameter int          TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        io_sel,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_ONE = 1;
  localparam logic [TX_AW:0] TX_ONE = 1;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CNTCLR = 8'h18;

  // Handshake: a byte moves on a uart port only in a cycle where valid and
  // ready are both high at the clock edge; valid never depends on ready.

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     tx_mem_d [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    cycle_q, cycle_d, inst_q, inst_d;
  logic           rx_overrun_q, rx_overrun_d, tx_overflow_q, tx_overflow_d;

  logic [7:0]  off;
  logic        ld, st;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_push, rx_pop, tx_push, tx_pop, tx_drop, cnt_clr, flag_clr;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign io_sel = (addr[31:8] == IO_BASE[31:8]);
  assign off    = addr[7:0];
  assign ld     = re && io_sel;
  assign st     = we && io_sel;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
  assign rdata         = rdata_q;

  assign rx_push  = uart_rx_valid && !rx_full;
  assign rx_pop   = ld && (off == OFF_RXDATA) && !rx_empty;
  assign tx_pop   = !tx_empty && uart_tx_ready;
  assign tx_push  = st && (off == OFF_TXDATA) && !tx_full;
  assign tx_drop  = st && (off == OFF_TXDATA) && tx_full;
  assign cnt_clr  = st && (off == OFF_CNTCLR);
  assign flag_clr = st && (off == OFF_STATUS);

  always_comb begin
    rd_val = 32'd0;
    case (off)
      OFF_STATUS: rd_val = {28'd0, tx_overflow_q, rx_overrun_q, !rx_empty, !tx_full};
      OFF_RXDATA: if (!rx_empty) rd_val = {24'd0, rx_mem_q[rx_rptr_q[RX_AW-1:0]]};
      OFF_CYCLE:  rd_val = cycle_q;
      OFF_INST:   rd_val = inst_q;
      default:    rd_val = 32'd0;
    endcase
  end

  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rdata_d   = rdata_q;
    cycle_d   = cycle_q + 32'd1;
    inst_d    = inst_q + {31'd0, inst_retired};

    if (rx_push) begin
      rx_mem_d[rx_wptr_q[RX_AW-1:0]] = uart_rx_data;
      rx_wptr_d = rx_wptr_q + RX_ONE;
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + RX_ONE;

    if (tx_push) begin
      tx_mem_d[tx_wptr_q[TX_AW-1:0]] = wdata[7:0];
      tx_wptr_d = tx_wptr_q + TX_ONE;
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + TX_ONE;

    if (ld) rdata_d = rd_val;

    // Counter clear takes priority over a same-cycle increment.
    if (cnt_clr) begin
      cycle_d = 32'd0;
      inst_d  = 32'd0;
    end

    // A new event in the same cycle as a clear leaves the flag set.
    rx_overrun_d  = (rx_overrun_q && !flag_clr) || (uart_rx_valid && rx_full);
    tx_overflow_d = (tx_overflow_q && !flag_clr) || tx_drop;
  end

  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      rdata_q       <= 32'd0;
      cycle_q       <= 32'd0;
      inst_q        <= 32'd0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      rdata_q       <= rdata_d;
      cycle_q       <= cycle_d;
      inst_q        <= inst_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] IO_BASE  = 32'h8000_0000;
  localparam int          RX_DEPTH = 8;
  localparam int          TX_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        io_sel;
  logic [31:0] rdata;
  logic        inst_retired = 1'b0;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.IO_BASE(IO_BASE), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .io_sel(io_sel), .rdata(rdata), .inst_retired(inst_retired),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [31:0] m_cyc, m_inst, m_rdata;
  logic        m_ovr, m_ofl;
  logic        m_sel, m_rxf, m_txf, m_set_ovr, m_set_ofl, m_clr;
  logic [7:0]  m_off;

  function automatic logic [31:0] m_status();
    return {28'd0, m_ofl, m_ovr, (m_rx.size() != 0), (m_tx.size() != TX_DEPTH)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rx.delete();
      m_tx.delete();
      m_cyc = 0; m_inst = 0; m_rdata = 0; m_ovr = 0; m_ofl = 0;
    end else begin
      m_sel = (addr[31:8] == IO_BASE[31:8]);
      m_off = addr[7:0];
      m_rxf = (m_rx.size() == RX_DEPTH);
      m_txf = (m_tx.size() == TX_DEPTH);
      m_set_ovr = uart_rx_valid && m_rxf;
      m_set_ofl = 1'b0;
      m_clr = we && m_sel && (m_off == 8'h00);
      if (re && m_sel) begin
        case (m_off)
          8'h00: m_rdata = m_status();
          8'h04: m_rdata = (m_rx.size() > 0) ? {24'd0, m_rx.pop_front()} : 32'd0;
          8'h10: m_rdata = m_cyc;
          8'h14: m_rdata = m_inst;
          default: m_rdata = 32'd0;
        endcase
      end
      if (uart_rx_valid && !m_rxf) m_rx.push_back(uart_rx_data);
      if (m_tx.size() > 0 && uart_tx_ready) void'(m_tx.pop_front());
      if (we && m_sel && m_off == 8'h08) begin
        if (m_txf) m_set_ofl = 1'b1;
        else m_tx.push_back(wdata[7:0]);
      end
      m_ovr = (m_ovr && !m_clr) || m_set_ovr;
      m_ofl = (m_ofl && !m_clr) || m_set_ofl;
      if (we && m_sel && m_off == 8'h18) begin
        m_cyc = 0;
        m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1;
        m_inst = m_inst + {31'd0, inst_retired};
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("io_sel", io_sel, addr[31:8] == IO_BASE[31:8]);
    check("rdata", rdata, m_rdata);
    check("rx_ready", uart_rx_ready, m_rx.size() < RX_DEPTH);
    check("tx_valid", uart_tx_valid, m_tx.size() > 0);
    if (m_tx.size() > 0) check("tx_data", uart_tx_data, m_tx[0]);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [7:0] o, output logic [31:0] d);
    addr = IO_BASE | {24'd0, o};
    re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic cpu_write(input logic [7:0] o, input logic [31:0] v);
    addr = IO_BASE | {24'd0, o};
    wdata = v;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] b);
    logic ok;
    logic rdy;
    ok = 1'b0;
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rdy = uart_rx_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    uart_rx_valid = 1'b0;
    check("uart_send_accepted", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [7:0]  got[$];
  logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
  int          k;

  initial begin
    repeat (3) tick();
    check("reset_rdata", rdata, 32'd0);
    check("reset_rx_ready", uart_rx_ready, 1);
    check("reset_tx_valid", uart_tx_valid, 0);
    rst_n = 1'b1;
    tick();
    cpu_read(8'h00, d);
    check("reset_status", d, 32'h1);

    // Single byte loopback through CPU.
    uart_send(8'h7A);
    for (int i = 0; i < 50; i++) begin
      cpu_read(8'h00, d);
      if (d[1]) break;
    end
    check("poll_rx_valid", d[1], 1);
    cpu_read(8'h04, d);
    check("rx_byte_7a", d, 32'h7A);
    cpu_write(8'h08, 32'h7A);
    check("tx_valid_7a", uart_tx_valid, 1);
    check("tx_data_7a", uart_tx_data, 8'h7A);
    cpu_read(8'h00, d);
    check("status_rx_cleared", d, 32'h1);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;

    // TX overflow: nine stores into an eight-deep stalled FIFO.
    for (int i = 0; i < 9; i++) cpu_write(8'h08, 32'h41 + i);
    cpu_read(8'h00, d);
    check("status_tx_overflow", d, 32'h8);
    uart_tx_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (uart_tx_valid) got.push_back(uart_tx_data);
      tick();
    end
    uart_tx_ready = 1'b0;
    check("tx_emitted_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("tx_order", got[i], 8'h41 + i);
    cpu_write(8'h00, 32'h0);
    cpu_read(8'h00, d);
    check("status_after_clear1", d, 32'h1);

    // RX overrun: ten bytes offered with no reads.
    fork
      begin
        for (int i = 1; i <= 10; i++) uart_send(8'h10 + i[7:0]);
      end
      begin
        repeat (20) tick();
        check("rx_ready_full", uart_rx_ready, 0);
        cpu_read(8'h00, d);
        check("status_overrun", d, 32'h7);
        for (int i = 1; i <= 10; i++) begin
          cpu_read(8'h04, d);
          check("rx_order", d, 32'h10 + i);
        end
      end
    join

    // Empty read and flag clear.
    cpu_read(8'h04, d);
    check("rx_empty_read", d, 32'h0);
    cpu_write(8'h00, 32'hFFFF_FFFF);
    cpu_read(8'h00, d);
    check("status_after_clear2", d, 32'h1);

    // Counters: 100 cycles with exactly 37 retired instructions.
    cpu_write(8'h18, 32'h0);
    k = 37;
    for (int n = 100; n > 0; n--) begin
      inst_retired = ($urandom_range(0, n - 1) < k);
      if (inst_retired) k--;
      tick();
    end
    inst_retired = 1'b0;
    cpu_read(8'h10, d);
    check("cycle_count", d, 32'd100);
    cpu_read(8'h14, d);
    check("inst_count", d, 32'd37);
    cpu_write(8'h18, 32'h1234);
    cpu_read(8'h10, d);
    check("cycle_after_clear", d, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      addr = ($urandom_range(0, 15) == 0) ? 32'h0000_1004 : (IO_BASE | {24'd0, offs[$urandom_range(0, 7)]});
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      inst_retired = $urandom_range(0, 1);
      uart_rx_valid = $urandom_range(0, 1);
      uart_rx_data = $urandom_range(0, 255);
      uart_tx_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    we = 1'b0; re = 1'b0; inst_retired = 1'b0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    tick();

    // Reset in the middle of traffic.
    cpu_write(8'h08, 32'hA1);
    cpu_write(8'h08, 32'hA2);
    uart_rx_data = 8'h55;
    uart_rx_valid = 1'b1;
    addr = IO_BASE | 32'h10;
    re = 1'b1;
    tick();
    re = 1'b0;
    #2;
    rst_n = 1'b0;
    uart_rx_valid = 1'b0;
    repeat (30) tick();
    check("midreset_rdata", rdata, 32'd0);
    check("midreset_rx_ready", uart_rx_ready, 1);
    check("midreset_tx_valid", uart_tx_valid, 0);
    rst_n = 1'b1;
    tick();
    cpu_read(8'h00, d);
    check("midreset_status", d, 32'h1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
